// File: rtl/display_timings_pkg.sv
// 640x480@60 timing constants shared by the timing generator, the renderer and the bench.
// Positions are zero-based; the active region always starts at sx=0, sy=0.
package display_timings_pkg;

  localparam int CORDW = 10;
  localparam int FCW   = 16;

  localparam int H_RES  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;

  localparam int V_RES  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam bit H_POL = 1'b0;
  localparam bit V_POL = 1'b0;

  function automatic int span_total(input int res, input int fp, input int sync, input int bp);
    return res + fp + sync + bp;
  endfunction

  localparam int H_TOTAL = span_total(H_RES, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span_total(V_RES, V_FP, V_SYNC, V_BP);

  // Sync windows are inclusive on both ends.
  localparam int HS_STA = H_RES + H_FP;
  localparam int HS_END = HS_STA + H_SYNC - 1;
  localparam int VS_STA = V_RES + V_FP;
  localparam int VS_END = VS_STA + V_SYNC - 1;

endpackage

// File: rtl/display_timings_480p.sv
// Pixel-clock timing generator: sx/sy counters with registered sync, enable and strobe decode.
// All decode looks at the next counter values so every output lines up with sx/sy in the same cycle.
module display_timings_480p #(
  parameter int CORDW  = display_timings_pkg::CORDW,
  parameter int FCW    = display_timings_pkg::FCW,
  parameter int H_RES  = display_timings_pkg::H_RES,
  parameter int H_FP   = display_timings_pkg::H_FP,
  parameter int H_SYNC = display_timings_pkg::H_SYNC,
  parameter int H_BP   = display_timings_pkg::H_BP,
  parameter int V_RES  = display_timings_pkg::V_RES,
  parameter int V_FP   = display_timings_pkg::V_FP,
  parameter int V_SYNC = display_timings_pkg::V_SYNC,
  parameter int V_BP   = display_timings_pkg::V_BP,
  parameter bit H_POL  = display_timings_pkg::H_POL,
  parameter bit V_POL  = display_timings_pkg::V_POL
) (
  input  logic             clk_pix,
  input  logic             rst,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line,
  output logic             frame,
  output logic [FCW-1:0]   frame_cnt
);

  localparam int H_TOTAL = display_timings_pkg::span_total(H_RES, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = display_timings_pkg::span_total(V_RES, V_FP, V_SYNC, V_BP);

  // H_TOTAL-1 and V_TOTAL-1 must fit in CORDW bits; all compares are unsigned.
  localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_STA = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_END = CORDW'(H_RES + H_FP + H_SYNC - 1);
  localparam logic [CORDW-1:0] VS_STA = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_END = CORDW'(V_RES + V_FP + V_SYNC - 1);

  logic [CORDW-1:0] r_sx;
  logic [CORDW-1:0] r_sy;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_de;
  logic             r_line;
  logic             r_frame;
  logic [FCW-1:0]   r_frame_cnt;

  logic             w_h_wrap;
  logic [CORDW-1:0] w_sx_next;
  logic [CORDW-1:0] w_sy_next;
  logic             w_hs_act;
  logic             w_vs_act;
  logic             w_de_next;
  logic             w_line_next;
  logic             w_frame_next;

  always_comb begin
    w_h_wrap  = (r_sx == H_LAST);
    w_sx_next = w_h_wrap ? '0 : r_sx + 1'b1;
    w_sy_next = r_sy;
    if (w_h_wrap) begin
      w_sy_next = (r_sy == V_LAST) ? '0 : r_sy + 1'b1;
    end
    w_hs_act     = (w_sx_next >= HS_STA) && (w_sx_next <= HS_END);
    // vsync only depends on sy, so it changes exactly when sx wraps to 0.
    w_vs_act     = (w_sy_next >= VS_STA) && (w_sy_next <= VS_END);
    w_de_next    = (w_sx_next < H_ACT) && (w_sy_next < V_ACT);
    w_line_next  = (w_sx_next == '0);
    w_frame_next = w_line_next && (w_sy_next == V_ACT);
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      r_sx        <= H_LAST;
      r_sy        <= V_LAST;
      r_hsync     <= ~H_POL;
      r_vsync     <= ~V_POL;
      r_de        <= 1'b0;
      r_line      <= 1'b0;
      r_frame     <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_sx    <= w_sx_next;
      r_sy    <= w_sy_next;
      r_hsync <= w_hs_act ? H_POL : ~H_POL;
      r_vsync <= w_vs_act ? V_POL : ~V_POL;
      r_de    <= w_de_next;
      r_line  <= w_line_next;
      r_frame <= w_frame_next;
      if (w_frame_next) begin
        r_frame_cnt <= r_frame_cnt + FCW'(1);
      end
    end
  end

  assign sx        = r_sx;
  assign sy        = r_sy;
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign de        = r_de;
  assign line      = r_line;
  assign frame     = r_frame;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_display_timings_480p.sv
// Directed bench: full 640x480 instance for reset/line/reset-mid-line checks, plus a tiny
// 15x8 instance (FCW=2, active-high hsync) for frame period, vsync, wrap and frame_cnt checks.
module tb_display_timings_480p;

  logic       clk_pix = 1'b0;
  logic       rst;
  logic       rst_s;

  logic [9:0]  sx, sy;
  logic        hsync, vsync, de, line, frame;
  logic [15:0] frame_cnt;

  logic [9:0]  s_sx, s_sy;
  logic        s_hsync, s_vsync, s_de, s_line, s_frame;
  logic [1:0]  s_frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  int de_cnt, de_err, hs_cnt, hs_first, hs_last, line_cnt, fr_cnt, pos_err, found;
  int ex_sx, ex_sy, prev_sx, prev_sy, range_err, sig_err, frames, last_fr, per_err;
  int cnt_err, wraps, wrap_err, vs_cnt;
  logic [1:0] prev_fc;
  logic exp_hs, exp_vs, exp_de, exp_line, exp_fr;

  // clock / reset
  always #5 clk_pix = ~clk_pix;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  display_timings_480p dut (
    .clk_pix  (clk_pix),
    .rst      (rst),
    .sx       (sx),
    .sy       (sy),
    .hsync    (hsync),
    .vsync    (vsync),
    .de       (de),
    .line     (line),
    .frame    (frame),
    .frame_cnt(frame_cnt)
  );

  display_timings_480p #(
    .CORDW(10), .FCW(2),
    .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_RES(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b0)
  ) dut_s (
    .clk_pix  (clk_pix),
    .rst      (rst_s),
    .sx       (s_sx),
    .sy       (s_sy),
    .hsync    (s_hsync),
    .vsync    (s_vsync),
    .de       (s_de),
    .line     (s_line),
    .frame    (s_frame),
    .frame_cnt(s_frame_cnt)
  );

  // driver tasks: inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(posedge clk_pix);
    @(negedge clk_pix);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    rst   = 1'b1;
    rst_s = 1'b1;
    @(negedge clk_pix);
    step(); step(); step();

    // reset state, full-size instance
    check("rst_sx", 32'(sx), 799);
    check("rst_sy", 32'(sy), 524);
    check("rst_hsync", 32'(hsync), 1);
    check("rst_vsync", 32'(vsync), 1);
    check("rst_de", 32'(de), 0);
    check("rst_line", 32'(line), 0);
    check("rst_frame", 32'(frame), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);

    // first cycle after release
    rst = 1'b0;
    step();
    check("first_sx", 32'(sx), 0);
    check("first_sy", 32'(sy), 0);
    check("first_de", 32'(de), 1);
    check("first_line", 32'(line), 1);
    check("first_hsync", 32'(hsync), 1);
    check("first_vsync", 32'(vsync), 1);
    check("first_frame", 32'(frame), 0);

    // one full line
    de_cnt = 0; de_err = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
    line_cnt = 0; fr_cnt = 0; pos_err = 0;
    for (int i = 0; i < 800; i++) begin
      if (32'(sx) !== 32'(i) || sy !== 10'd0) pos_err++;
      if (de) de_cnt++;
      if (de !== (i < 640)) de_err++;
      if (!hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = i;
        hs_last = i;
      end
      if (line) line_cnt++;
      if (frame) fr_cnt++;
      step();
    end
    check("line_pos", 32'(pos_err), 0);
    check("line_de_cnt", 32'(de_cnt), 640);
    check("line_de_window", 32'(de_err), 0);
    check("line_hs_cnt", 32'(hs_cnt), 96);
    check("line_hs_first", 32'(hs_first), 656);
    check("line_hs_last", 32'(hs_last), 751);
    check("line_strobes", 32'(line_cnt), 1);
    check("line_no_frame", 32'(fr_cnt), 0);
    check("line2_sx", 32'(sx), 0);
    check("line2_sy", 32'(sy), 1);
    check("line2_line", 32'(line), 1);

    // reset in the middle of the hsync pulse
    found = 0;
    for (int i = 0; i < 900; i++) begin
      if (sx == 10'd700) begin
        found = 1;
        break;
      end
      step();
    end
    check("reach_sx700", 32'(found), 1);
    check("sx700_hsync", 32'(hsync), 0);
    rst = 1'b1;
    step();
    check("midrst_hsync", 32'(hsync), 1);
    check("midrst_sx", 32'(sx), 799);
    check("midrst_sy", 32'(sy), 524);
    check("midrst_de", 32'(de), 0);
    check("midrst_frame_cnt", 32'(frame_cnt), 0);
    rst = 1'b0;
    step();
    check("restart_sx", 32'(sx), 0);
    check("restart_sy", 32'(sy), 0);
    check("restart_line", 32'(line), 1);

    // small instance: 15 x 8 total, hs [10,12] active-high, vs rows [5,6], frame at sy=4
    check("s_rst_sx", 32'(s_sx), 14);
    check("s_rst_sy", 32'(s_sy), 7);
    check("s_rst_hsync", 32'(s_hsync), 0);
    check("s_rst_vsync", 32'(s_vsync), 1);
    check("s_rst_de", 32'(s_de), 0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    rst_s = 1'b0;
    step();

    pos_err = 0; range_err = 0; sig_err = 0; frames = 0; last_fr = -1; per_err = 0;
    cnt_err = 0; wraps = 0; wrap_err = 0; vs_cnt = 0;
    prev_fc = 2'd0; prev_sx = -1; prev_sy = -1;
    for (int c = 0; c < 600; c++) begin
      ex_sx    = c % 15;
      ex_sy    = (c / 15) % 8;
      exp_hs   = (ex_sx >= 10) && (ex_sx <= 12);
      exp_vs   = !((ex_sy >= 5) && (ex_sy <= 6));
      exp_de   = (ex_sx < 8) && (ex_sy < 4);
      exp_line = (ex_sx == 0);
      exp_fr   = (ex_sx == 0) && (ex_sy == 4);
      if (32'(s_sx) !== 32'(ex_sx) || 32'(s_sy) !== 32'(ex_sy)) pos_err++;
      if (s_sx >= 10'd15 || s_sy >= 10'd8) range_err++;
      if (s_hsync !== exp_hs || s_vsync !== exp_vs || s_de !== exp_de ||
          s_line !== exp_line || s_frame !== exp_fr) sig_err++;
      if (!s_vsync) vs_cnt++;
      if (s_frame) begin
        frames++;
        if (last_fr >= 0 && (c - last_fr) != 120) per_err++;
        last_fr = c;
        if (exp_q.size() > 0) check("frame_cnt_seq", 32'(s_frame_cnt), 32'(exp_q.pop_front()));
      end
      if (s_frame_cnt !== prev_fc && !s_frame) cnt_err++;
      prev_fc = s_frame_cnt;
      if (prev_sx == 14 && prev_sy == 7) begin
        wraps++;
        if (!(s_sx == 10'd0 && s_sy == 10'd0 && s_de)) wrap_err++;
      end
      prev_sx = 32'(s_sx);
      prev_sy = 32'(s_sy);
      step();
    end
    check("s_pos", 32'(pos_err), 0);
    check("s_range", 32'(range_err), 0);
    check("s_signals", 32'(sig_err), 0);
    check("s_vsync_cycles", 32'(vs_cnt), 150);
    check("s_frames", 32'(frames), 5);
    check("s_frame_period", 32'(per_err), 0);
    check("s_cnt_only_on_frame", 32'(cnt_err), 0);
    check("s_wraps", 32'(wraps), 4);
    check("s_wrap_ok", 32'(wrap_err), 0);
    check("s_exp_q_empty", 32'(exp_q.size()), 0);
    check("s_pre_rst_frame_cnt", 32'(s_frame_cnt), 1);

    // reset with a nonzero frame count
    rst_s = 1'b1;
    step();
    check("s_midrst_frame_cnt", 32'(s_frame_cnt), 0);
    check("s_midrst_sx", 32'(s_sx), 14);
    check("s_midrst_sy", 32'(s_sy), 7);
    check("s_midrst_hsync", 32'(s_hsync), 0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
